// File: rtl/jtag_tap_sampled.sv
`default_nettype none
// ============================================================================
// Module   : jtag_tap_sampled
// Purpose  : Oversampled IEEE 1149.1 TAP controller. TCK/TMS/TDI/TRSTN are
//            synchronized into clk, TCK edges are detected, and the TAP FSM,
//            IR, IDCODE, BYPASS and DBG data registers all run on clk.
// Revision : 1.0 - initial release
// ============================================================================
module jtag_tap_sampled #(
   parameter int                     IR_WIDTH     = 5,
   parameter logic [31:0]            IDCODE_VALUE = 32'h1000_0A6D,
   parameter int                     DBG_DR_WIDTH = 32,
   parameter logic [IR_WIDTH-1:0]    INSN_IDCODE  = 'h01,
   parameter logic [IR_WIDTH-1:0]    INSN_DBG     = 'h10,
   parameter logic [IR_WIDTH-1:0]    INSN_BYPASS  = 'h1F
) (
   input  logic                     clk,
   input  logic                     rstn,
   input  logic                     tck,
   input  logic                     tms,
   input  logic                     tdi,
   input  logic                     trstn,
   output logic                     tdo,
   output logic                     tdo_en,
   output logic [3:0]               tap_state,
   output logic [IR_WIDTH-1:0]      ir,
   output logic                     dbg_capture,
   input  logic [DBG_DR_WIDTH-1:0]  dbg_capture_data,
   output logic                     dbg_update,
   output logic [DBG_DR_WIDTH-1:0]  dbg_update_data
);

   typedef enum logic [3:0] {
      TLR   = 4'hF, RTI   = 4'hC, SELDR = 4'h7, CAPDR = 4'h6,
      SHDR  = 4'h2, EX1DR = 4'h1, PADR  = 4'h3, EX2DR = 4'h0,
      UPDR  = 4'h5, SELIR = 4'h4, CAPIR = 4'hE, SHIR  = 4'hA,
      EX1IR = 4'h9, PAIR  = 4'hB, EX2IR = 4'h8, UPIR  = 4'hD
   } tap_state_t;

   // synchronizer and edge-detect flops
   logic tck_s1, tck_s2, tck_s3;
   logic tms_s1, tms_s2;
   logic tdi_s1, tdi_s2;
   logic trstn_s1, trstn_s2;
   logic tck_rise, tck_fall;

   tap_state_t state, state_next, prev_state;

   logic [IR_WIDTH-1:0]     ir_sr;
   logic [31:0]             idcode_sr;
   logic                    bypass_sr;
   logic [DBG_DR_WIDTH-1:0] dbg_sr;

   logic sel_idcode, sel_dbg, rise_ok, tdo_next;

   // two-flop synchronizers; trstn idles high so its flops reset to 1
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         tck_s1   <= 1'b0; tck_s2   <= 1'b0; tck_s3 <= 1'b0;
         tms_s1   <= 1'b0; tms_s2   <= 1'b0;
         tdi_s1   <= 1'b0; tdi_s2   <= 1'b0;
         trstn_s1 <= 1'b1; trstn_s2 <= 1'b1;
      end else begin
         tck_s1   <= tck;   tck_s2   <= tck_s1;  tck_s3 <= tck_s2;
         tms_s1   <= tms;   tms_s2   <= tms_s1;
         tdi_s1   <= tdi;   tdi_s2   <= tdi_s1;
         trstn_s1 <= trstn; trstn_s2 <= trstn_s1;
      end
   end

   assign tck_rise   = tck_s2 & ~tck_s3;
   assign tck_fall   = ~tck_s2 & tck_s3;
   // a rising edge coinciding with test reset is discarded: TLR wins
   assign rise_ok    = tck_rise & trstn_s2;
   assign sel_idcode = (ir == INSN_IDCODE);
   assign sel_dbg    = (ir == INSN_DBG);
   assign tap_state  = state;

   // TAP state register, plus previous state for capture-strobe detection
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state      <= TLR;
         prev_state <= TLR;
      end else begin
         state      <= state_next;
         prev_state <= state;
      end
   end

   // IEEE 1149.1 next-state logic, advanced on each synced TCK rise
   always_comb begin
      state_next = state;
      if (!trstn_s2) begin
         state_next = TLR;
      end else if (tck_rise) begin
         case (state)
            TLR:     state_next = tms_s2 ? TLR   : RTI;
            RTI:     state_next = tms_s2 ? SELDR : RTI;
            SELDR:   state_next = tms_s2 ? SELIR : CAPDR;
            CAPDR:   state_next = tms_s2 ? EX1DR : SHDR;
            SHDR:    state_next = tms_s2 ? EX1DR : SHDR;
            EX1DR:   state_next = tms_s2 ? UPDR  : PADR;
            PADR:    state_next = tms_s2 ? EX2DR : PADR;
            EX2DR:   state_next = tms_s2 ? UPDR  : SHDR;
            UPDR:    state_next = tms_s2 ? SELDR : RTI;
            SELIR:   state_next = tms_s2 ? TLR   : CAPIR;
            CAPIR:   state_next = tms_s2 ? EX1IR : SHIR;
            SHIR:    state_next = tms_s2 ? EX1IR : SHIR;
            EX1IR:   state_next = tms_s2 ? UPIR  : PAIR;
            PAIR:    state_next = tms_s2 ? EX2IR : PAIR;
            EX2IR:   state_next = tms_s2 ? UPIR  : SHIR;
            UPIR:    state_next = tms_s2 ? SELDR : RTI;
            default: state_next = TLR;
         endcase
      end
   end

   // capture and shift of IR and the selected DR, in the state being left
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         ir_sr     <= '0;
         idcode_sr <= '0;
         bypass_sr <= 1'b0;
         dbg_sr    <= '0;
      end else if (rise_ok) begin
         case (state)
            CAPIR: ir_sr <= {{(IR_WIDTH-1){1'b0}}, 1'b1};
            SHIR:  ir_sr <= {tdi_s2, ir_sr[IR_WIDTH-1:1]};
            CAPDR: begin
               if (sel_idcode)   idcode_sr <= IDCODE_VALUE;
               else if (sel_dbg) dbg_sr    <= dbg_capture_data;
               else              bypass_sr <= 1'b0;
            end
            SHDR: begin
               if (sel_idcode)   idcode_sr <= {tdi_s2, idcode_sr[31:1]};
               else if (sel_dbg) dbg_sr    <= {tdi_s2, dbg_sr[DBG_DR_WIDTH-1:1]};
               else              bypass_sr <= tdi_s2;
            end
            default: ;
         endcase
      end
   end

   // serial output source for the current shift state
   always_comb begin
      tdo_next = 1'b0;
      if (state == SHIR) begin
         tdo_next = ir_sr[0];
      end else if (state == SHDR) begin
         if (sel_idcode)   tdo_next = idcode_sr[0];
         else if (sel_dbg) tdo_next = dbg_sr[0];
         else              tdo_next = bypass_sr;
      end
   end

   // falling-edge actions: tdo launch, IR update, DBG update strobe;
   // any entry into TLR reloads the IDCODE instruction and idles tdo
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         tdo             <= 1'b0;
         tdo_en          <= 1'b0;
         ir              <= INSN_IDCODE;
         dbg_update      <= 1'b0;
         dbg_update_data <= '0;
      end else begin
         dbg_update <= 1'b0;
         if (!trstn_s2) begin
            tdo    <= 1'b0;
            tdo_en <= 1'b0;
         end else if (tck_fall) begin
            tdo    <= tdo_next;
            tdo_en <= (state == SHIR) || (state == SHDR);
            if (state == UPIR) ir <= ir_sr;
            if (state == UPDR && sel_dbg) begin
               dbg_update_data <= dbg_sr;
               dbg_update      <= 1'b1;
            end
         end
         if (state_next == TLR) ir <= INSN_IDCODE;
      end
   end

   // one-clk capture request in the cycle after CapDR is entered under DBG
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) dbg_capture <= 1'b0;
      else       dbg_capture <= (state == CAPDR) && (prev_state != CAPDR) && sel_dbg;
   end

endmodule
`default_nettype wire

// File: tb/tb_jtag_tap_sampled.sv
`default_nettype none
// ============================================================================
// Module   : tb_jtag_tap_sampled
// Purpose  : Self-checking bench for jtag_tap_sampled: bit-banged TCK,
//            expected tdo bits queued per shift, table of IR/DR scans.
// Revision : 1.0 - initial release
// ============================================================================
module tb_jtag_tap_sampled;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        tck = 1'b0, tms = 1'b1, tdi = 1'b0, trstn = 1'b1;
   logic        tdo, tdo_en, dbg_capture, dbg_update;
   logic [3:0]  tap_state;
   logic [4:0]  ir;
   logic [31:0] dbg_capture_data = 32'hDEAD_BEEF;
   logic [31:0] dbg_update_data;

   int tests = 0;
   int fails = 0;
   int cap_cnt = 0;
   int upd_cnt = 0;
   bit exp_q[$];

   typedef struct {
      logic [4:0]  insn;
      logic [31:0] din;
      int          len;
      logic [31:0] dout;
      int          caps;
      int          upds;
      logic [31:0] upd_data;
   } scan_vec_t;

   scan_vec_t vecs[5];

   jtag_tap_sampled dut (
      .clk(clk), .rstn(rstn), .tck(tck), .tms(tms), .tdi(tdi), .trstn(trstn),
      .tdo(tdo), .tdo_en(tdo_en), .tap_state(tap_state), .ir(ir),
      .dbg_capture(dbg_capture), .dbg_capture_data(dbg_capture_data),
      .dbg_update(dbg_update), .dbg_update_data(dbg_update_data)
   );

   always #5 clk = ~clk;

   // strobe counters
   always @(posedge clk) begin
      if (dbg_capture) cap_cnt++;
      if (dbg_update)  upd_cnt++;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // one TCK period; optionally compares tdo against the next queued bit first
   task automatic pulse(input bit t_ms, input bit t_di, input bit chk_tdo);
      bit e;
      @(negedge clk);
      if (chk_tdo) begin
         if (exp_q.size() == 0) begin
            chk("scoreboard_empty", 32'd1, 32'd0);
         end else begin
            e = exp_q.pop_front();
            chk("tdo_en_shift", {31'd0, tdo_en}, 32'd1);
            chk("tdo_bit", {31'd0, tdo}, {31'd0, e});
         end
      end
      tms = t_ms;
      tdi = t_di;
      repeat (2) @(negedge clk);
      tck = 1'b1;
      repeat (8) @(negedge clk);
      tck = 1'b0;
      repeat (8) @(negedge clk);
   endtask

   // RTI -> IR scan -> RTI; captured IR pattern is 0..01
   task automatic scan_ir(input logic [4:0] v);
      pulse(1, 0, 0); pulse(1, 0, 0); pulse(0, 0, 0); pulse(0, 0, 0);
      for (int i = 0; i < 5; i++) exp_q.push_back(i == 0);
      for (int i = 0; i < 5; i++) pulse(i == 4, v[i], 1);
      pulse(1, 0, 0); pulse(0, 0, 0);
   endtask

   // RTI -> DR scan of n bits -> RTI
   task automatic scan_dr(input logic [31:0] din, input int n, input logic [31:0] dexp);
      pulse(1, 0, 0); pulse(0, 0, 0); pulse(0, 0, 0);
      for (int i = 0; i < n; i++) exp_q.push_back(dexp[i]);
      for (int i = 0; i < n; i++) pulse(i == n - 1, din[i], 1);
      pulse(1, 0, 0); pulse(0, 0, 0);
   endtask

   initial begin
      int c0, u0;
      vecs[0] = '{5'h01, 32'h0,         32, 32'h1000_0A6D, 0, 0, 32'h0};
      vecs[1] = '{5'h1F, 32'h0000_000D,  4, 32'h0000_000A, 0, 0, 32'h0};
      vecs[2] = '{5'h10, 32'h1234_5678, 32, 32'hDEAD_BEEF, 1, 1, 32'h1234_5678};
      vecs[3] = '{5'h05, 32'h0000_00A5,  8, 32'h0000_004A, 0, 0, 32'h1234_5678};
      vecs[4] = '{5'h01, 32'hFFFF_FFFF, 32, 32'h1000_0A6D, 0, 0, 32'h1234_5678};

      // reset and TLR via 5x TMS=1
      repeat (3) @(negedge clk);
      chk("rst_state", {28'd0, tap_state}, 32'hF);
      chk("rst_ir", {27'd0, ir}, 32'h01);
      chk("rst_upd_data", dbg_update_data, 32'h0);
      rstn = 1'b1;
      repeat (4) @(negedge clk);
      for (int i = 0; i < 5; i++) pulse(1, 0, 0);
      chk("tlr_state", {28'd0, tap_state}, 32'hF);
      chk("tlr_ir", {27'd0, ir}, 32'h01);
      chk("tlr_tdo_en", {31'd0, tdo_en}, 32'd0);
      chk("tlr_strobes", cap_cnt + upd_cnt, 32'd0);

      // default instruction after TLR is IDCODE
      pulse(0, 0, 0);
      chk("rti_state", {28'd0, tap_state}, 32'hC);
      scan_dr(32'h0, 32, 32'h1000_0A6D);

      // table of IR load + DR scan
      for (int k = 0; k < 5; k++) begin
         c0 = cap_cnt; u0 = upd_cnt;
         scan_ir(vecs[k].insn);
         chk("ir_loaded", {27'd0, ir}, {27'd0, vecs[k].insn});
         scan_dr(vecs[k].din, vecs[k].len, vecs[k].dout);
         chk("end_state", {28'd0, tap_state}, 32'hC);
         chk("idle_tdo_en", {31'd0, tdo_en}, 32'd0);
         chk("capture_pulses", cap_cnt - c0, vecs[k].caps);
         chk("update_pulses", upd_cnt - u0, vecs[k].upds);
         chk("update_data", dbg_update_data, vecs[k].upd_data);
      end

      // trstn mid-ShDR under DBG: forced to TLR, no update
      scan_ir(5'h10);
      u0 = upd_cnt;
      pulse(1, 0, 0); pulse(0, 0, 0); pulse(0, 0, 0);
      for (int i = 0; i < 3; i++) exp_q.push_back(dbg_capture_data[i]);
      for (int i = 0; i < 3; i++) pulse(0, 1, 1);
      chk("pre_trst_state", {28'd0, tap_state}, 32'h2);
      @(negedge clk);
      trstn = 1'b0;
      repeat (4) @(negedge clk);
      chk("trst_state", {28'd0, tap_state}, 32'hF);
      chk("trst_ir", {27'd0, ir}, 32'h01);
      chk("trst_tdo_en", {31'd0, tdo_en}, 32'd0);
      trstn = 1'b1;
      repeat (4) @(negedge clk);
      chk("trst_no_update", upd_cnt - u0, 32'd0);
      chk("trst_upd_data", dbg_update_data, 32'h1234_5678);
      pulse(0, 0, 0);
      chk("post_trst_rti", {28'd0, tap_state}, 32'hC);

      // rstn during a partial IR shift: asynchronous return to reset values
      pulse(1, 0, 0); pulse(1, 0, 0); pulse(0, 0, 0); pulse(0, 0, 0);
      pulse(0, 1, 0); pulse(0, 1, 0);
      chk("pre_rst_state", {28'd0, tap_state}, 32'hA);
      @(negedge clk);
      rstn = 1'b0;
      #1;
      chk("arst_state", {28'd0, tap_state}, 32'hF);
      chk("arst_ir", {27'd0, ir}, 32'h01);
      chk("arst_tdo", {30'd0, tdo, tdo_en}, 32'd0);
      chk("arst_upd_data", dbg_update_data, 32'h0);
      repeat (2) @(negedge clk);
      rstn = 1'b1;
      repeat (4) @(negedge clk);
      pulse(0, 0, 0);
      c0 = cap_cnt; u0 = upd_cnt;
      scan_ir(5'h10);
      chk("post_rst_ir", {27'd0, ir}, 32'h10);
      dbg_capture_data = 32'h0F0F_A5A5;
      scan_dr(32'hCAFE_0001, 32, 32'h0F0F_A5A5);
      chk("post_rst_caps", cap_cnt - c0, 32'd1);
      chk("post_rst_upds", upd_cnt - u0, 32'd1);
      chk("post_rst_upd_data", dbg_update_data, 32'hCAFE_0001);
      chk("scoreboard_drained", exp_q.size(), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
